// File: rtl/snake_input_ctrl_pkg.sv
// Shared snake game definitions: heading encoding, reset heading and
// the reversal helper. Used by the input front-end and the movement engine.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  localparam dir_t DIR_RESET = DIR_RIGHT;

  // Opposite heading: flipping bit 1 maps up<->down and right<->left.
  function automatic dir_t dir_opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_input_ctrl_if.sv
// Button/tick inputs and heading/queue outputs of the snake input front-end.
// master = stimulus side (buttons, tick), slave = snake_input_ctrl.
interface snake_input_ctrl_if;
  import snake_pkg::*;

  logic [3:0] btn_i;
  logic       tick_i;
  dir_t       dir_o;
  logic       turn_taken_o;
  logic [1:0] pending_o;

  modport master (
    output btn_i, tick_i,
    input  dir_o, turn_taken_o, pending_o
  );

  modport slave (
    input  btn_i, tick_i,
    output dir_o, turn_taken_o, pending_o
  );
endinterface

// File: rtl/snake_input_ctrl_debounce.sv
// One button: 2-FF synchroniser, stability counter and debounced level.
// rise_o is a registered one-cycle pulse on the rising edge of level_o.
module snake_debounce #(
  parameter int DEBOUNCE_MAX = 50000,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic level_o,
  output logic rise_o
);

  logic             r_sync_p0;
  logic             r_sync_p1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             w_done;

  // The counter has seen DEBOUNCE_MAX-1 differing cycles; this one completes it.
  assign w_done = (r_sync_p1 != r_level) && (r_cnt == CNT_W'(DEBOUNCE_MAX - 1));

  // Synchronise the raw button, then accept a new level once it has held long enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_sync_p0 <= i_btn;
      r_sync_p1 <= r_sync_p0;
      r_rise    <= w_done && r_sync_p1;
      if (r_sync_p1 == r_level) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_level <= r_sync_p1;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level_o = r_level;
  assign rise_o  = r_rise;

endmodule

// File: rtl/snake_input_ctrl.sv
// Snake input front-end: debounced direction buttons, turn legality check
// and a small turn FIFO drained one entry per game tick.
// Build option SNAKE_TURN_QUEUE_EN: defined -> two queued turns,
// undefined -> a single pending turn.
module snake_input_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_MAX = 50000,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  snake_input_ctrl_if.slave   bus
);

`ifdef SNAKE_TURN_QUEUE_EN
  localparam logic [1:0] Q_DEPTH = 2'd2;
`else
  localparam logic [1:0] Q_DEPTH = 2'd1;
`endif

  logic [3:0] w_level;
  logic [3:0] w_rise;
  logic       w_press_vld;
  dir_t       w_press_dir;
  dir_t       w_head;
  dir_t       w_tail;
  dir_t       w_ref;
  logic       w_pop;
  logic       w_push;
  logic [1:0] w_cnt_after_pop;

  dir_t       r_q [2];
  logic       r_rd;
  logic       r_wr;
  logic [1:0] r_cnt;
  dir_t       r_dir;
  logic       r_turn_taken;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    snake_debounce #(
      .DEBOUNCE_MAX (DEBOUNCE_MAX),
      .CNT_W        (CNT_W)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (bus.btn_i[g]),
      .level_o (w_level[g]),
      .rise_o  (w_rise[g])
    );
  end

  // Fixed priority among simultaneous presses: up > right > down > left.
  always_comb begin
    w_press_vld = 1'b1;
    w_press_dir = DIR_UP;
    if (w_rise[0] && w_level[0])      w_press_dir = DIR_UP;
    else if (w_rise[1] && w_level[1]) w_press_dir = DIR_RIGHT;
    else if (w_rise[2] && w_level[2]) w_press_dir = DIR_DOWN;
    else if (w_rise[3] && w_level[3]) w_press_dir = DIR_LEFT;
    else                              w_press_vld = 1'b0;
  end

  // The tail is the most recent write. After a same-cycle pop the post-pop
  // reference is the remaining tail, or the popped entry when it was the
  // only one -- both are the current tail, so one reference serves both cases.
  assign w_head          = r_q[r_rd];
  assign w_tail          = r_q[~r_wr];
  assign w_ref           = (r_cnt != 2'd0) ? w_tail : r_dir;
  assign w_pop           = bus.tick_i && (r_cnt != 2'd0);
  assign w_cnt_after_pop = r_cnt - {1'b0, w_pop};
  assign w_push          = w_press_vld && (w_cnt_after_pop < Q_DEPTH) &&
                           (w_press_dir != w_ref) &&
                           (w_press_dir != dir_opposite(w_ref));

  // Queue control, heading update and turn-taken pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_cnt        <= 2'd0;
      r_dir        <= DIR_RESET;
      r_turn_taken <= 1'b0;
    end else begin
      r_turn_taken <= w_pop;
      r_cnt        <= w_cnt_after_pop + {1'b0, w_push};
      if (w_pop) begin
        r_dir <= w_head;
        r_rd  <= ~r_rd;
      end
      if (w_push) begin
        r_wr <= ~r_wr;
      end
    end
  end

  // Queue storage; contents are only meaningful while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q[r_wr] <= w_press_dir;
    end
  end

  assign bus.dir_o        = r_dir;
  assign bus.turn_taken_o = r_turn_taken;
  assign bus.pending_o    = r_cnt;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Directed bench for snake_input_ctrl with DEBOUNCE_MAX = 4.
module tb_snake_input_ctrl;
  import snake_pkg::*;

`ifdef SNAKE_TURN_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  snake_input_ctrl_if bus ();

  snake_input_ctrl #(
    .DEBOUNCE_MAX (4),
    .CNT_W        (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    int         hold;
    bit         tick;
    dir_t       dir_q;
    logic [1:0] pend_q;
    bit         turn_q;
    dir_t       dir_s;
    logic [1:0] pend_s;
    bit         turn_s;
  } vec_t;

  vec_t vecs [17];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Hold a button mask, optionally ticking in the cycle its press is pushed,
  // then release and let the release debounce settle.
  task automatic press(input logic [3:0] m, input int hold, input bit tick_at_push);
    bus.btn_i = m;
    for (int k = 0; k < hold; k++) begin
      if (tick_at_push && k == 6) bus.tick_i = 1'b1;
      step();
      if (tick_at_push && k == 6) begin
        bus.tick_i = 1'b0;
        chk("push_pop_turn", {3'b0, bus.turn_taken_o}, 4'd1);
      end
    end
    bus.btn_i = 4'b0;
    repeat (8) step();
  endtask

  task automatic tick_once(input bit exp_turn);
    bus.tick_i = 1'b1;
    step();
    bus.tick_i = 1'b0;
    chk("turn_pulse", {3'b0, bus.turn_taken_o}, {3'b0, exp_turn});
    step();
    chk("turn_end", {3'b0, bus.turn_taken_o}, 4'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    //          btn      hold tick dir_q      pq  tq  dir_s      ps  ts
    vecs[0]  = '{4'b1000, 10, 0, DIR_RIGHT, 2'd0, 0, DIR_RIGHT, 2'd0, 0};
    vecs[1]  = '{4'b0010, 10, 0, DIR_RIGHT, 2'd0, 0, DIR_RIGHT, 2'd0, 0};
    vecs[2]  = '{4'b0001, 10, 0, DIR_RIGHT, 2'd1, 0, DIR_RIGHT, 2'd1, 0};
    vecs[3]  = '{4'b0000,  0, 1, DIR_UP,    2'd0, 1, DIR_UP,    2'd0, 1};
    vecs[4]  = '{4'b0000,  0, 1, DIR_UP,    2'd0, 0, DIR_UP,    2'd0, 0};
    vecs[5]  = '{4'b0010, 10, 0, DIR_UP,    2'd1, 0, DIR_UP,    2'd1, 0};
    vecs[6]  = '{4'b1000, 10, 0, DIR_UP,    2'd1, 0, DIR_UP,    2'd1, 0};
    vecs[7]  = '{4'b0000,  0, 1, DIR_RIGHT, 2'd0, 1, DIR_RIGHT, 2'd0, 1};
    vecs[8]  = '{4'b0100,  3, 0, DIR_RIGHT, 2'd0, 0, DIR_RIGHT, 2'd0, 0};
    vecs[9]  = '{4'b0101, 10, 0, DIR_RIGHT, 2'd1, 0, DIR_RIGHT, 2'd1, 0};
    vecs[10] = '{4'b0000,  0, 1, DIR_UP,    2'd0, 1, DIR_UP,    2'd0, 1};
    vecs[11] = '{4'b0100, 10, 0, DIR_UP,    2'd0, 0, DIR_UP,    2'd0, 0};
    vecs[12] = '{4'b1000, 10, 0, DIR_UP,    2'd1, 0, DIR_UP,    2'd1, 0};
    vecs[13] = '{4'b0100, 10, 0, DIR_UP,    2'd2, 0, DIR_UP,    2'd1, 0};
    vecs[14] = '{4'b0010, 10, 0, DIR_UP,    2'd2, 0, DIR_UP,    2'd1, 0};
    vecs[15] = '{4'b0000,  0, 1, DIR_LEFT,  2'd1, 1, DIR_LEFT,  2'd0, 1};
    vecs[16] = '{4'b0000,  0, 1, DIR_DOWN,  2'd0, 1, DIR_LEFT,  2'd0, 0};

    rst        = 1'b1;
    bus.btn_i  = 4'b0;
    bus.tick_i = 1'b0;
    repeat (3) step();
    chk("reset_dir",  {2'b0, bus.dir_o},        {2'b0, DIR_RIGHT});
    chk("reset_pend", {2'b0, bus.pending_o},    4'd0);
    chk("reset_turn", {3'b0, bus.turn_taken_o}, 4'd0);
    rst = 1'b0;
    step();

    // Press latency: pending rises exactly on the 7th edge after the press.
    bus.btn_i = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("latency_c%0d", k), {2'b0, bus.pending_o}, (k >= 7) ? 4'd1 : 4'd0);
    end
    repeat (3) step();
    bus.btn_i = 4'b0;
    repeat (8) step();
    chk("latency_hold", {2'b0, bus.pending_o}, 4'd1);

    // Asynchronous reset between clock edges clears the queue at once.
    #2 rst = 1'b1;
    #1;
    chk("midrst_pend", {2'b0, bus.pending_o},    4'd0);
    chk("midrst_dir",  {2'b0, bus.dir_o},        {2'b0, DIR_RIGHT});
    chk("midrst_turn", {3'b0, bus.turn_taken_o}, 4'd0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].btn != 4'b0) press(vecs[i].btn, vecs[i].hold, 1'b0);
      if (vecs[i].tick) tick_once(QEN ? vecs[i].turn_q : vecs[i].turn_s);
      chk($sformatf("vec%0d_dir", i),  {2'b0, bus.dir_o},
          {2'b0, QEN ? vecs[i].dir_q : vecs[i].dir_s});
      chk($sformatf("vec%0d_pend", i), {2'b0, bus.pending_o},
          {2'b0, QEN ? vecs[i].pend_q : vecs[i].pend_s});
    end

    // Opposite-of-head press landing with a tick is judged against the popped heading.
    do_reset();
    press(4'b0001, 10, 1'b0);
    press(4'b0100, 10, 1'b1);
    chk("popopp_dir",  {2'b0, bus.dir_o},     {2'b0, DIR_UP});
    chk("popopp_pend", {2'b0, bus.pending_o}, 4'd0);

    // A full queue still accepts a legal press when a tick frees a slot that cycle.
    press(4'b1000, 10, 1'b0);
`ifdef SNAKE_TURN_QUEUE_EN
    press(4'b0100, 10, 1'b0);
    chk("fullq_pend", {2'b0, bus.pending_o}, 4'd2);
    press(4'b0010, 10, 1'b1);
    chk("fullpush_dir",  {2'b0, bus.dir_o},     {2'b0, DIR_LEFT});
    chk("fullpush_pend", {2'b0, bus.pending_o}, 4'd2);
`else
    chk("fullq_pend", {2'b0, bus.pending_o}, 4'd1);
    press(4'b0001, 10, 1'b1);
    chk("fullpush_dir",  {2'b0, bus.dir_o},     {2'b0, DIR_LEFT});
    chk("fullpush_pend", {2'b0, bus.pending_o}, 4'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_input_ctrl.md
# snake_input_ctrl

Front-end of the snake game core, directly upstream of the movement/collision engine inside `tt_um_histefan_top`. Synchronises and debounces the four direction buttons on `ui_in[3:0]`. Rejects illegal turns (same direction or 180° reversal) and queues up to two pending turns. The engine consumes one turn per game step, so fast double-taps between steps are not lost.

## Interface
Parameters:
- `DEBOUNCE_MAX`, 50000: consecutive stable cycles required before a button level is accepted (1 ms at 50 MHz); set to 4 in simulation.
- `CNT_W`, 16: debounce counter width; must satisfy `DEBOUNCE_MAX < 2**CNT_W`.

Ports:
- `clk` in 1: system clock; all logic is rising-edge triggered on this single clock.
- `rst` in 1: reset, asynchronous and active-high. The top level drives it as `~rst_n`.
- `btn_i` in 4: raw asynchronous buttons from `ui_in[3:0]`: [0]=up, [1]=right, [2]=down, [3]=left; active-high.
- `tick_i` in 1: game-step strobe from the tick divider; single-cycle pulse.
- `dir_o` out 2: current snake heading: 00 up, 01 right, 10 down, 11 left.
- `turn_taken_o` out 1: one-cycle pulse in the cycle after a queued turn is applied to `dir_o`.
- `pending_o` out 2: number of queued turns, 0..2.

## Operation
- **Synchroniser:** each `btn_i` bit passes through a 2-FF synchroniser.
- **Debounce, per button:**
  - The counter resets to 0 whenever the synced level equals the stable level.
  - Otherwise the counter increments.
  - When the counter reaches `DEBOUNCE_MAX`, the stable level takes the synced level and the counter clears.
- **Press event:** a rising edge of the stable level. If several press events occur in the same cycle, priority is up > right > down > left. Only the winner is considered; the others are dropped.
- **Reference direction:** the tail of the queue if the queue is non-empty, otherwise `dir_o`.
- **Acceptance rule:** a press with direction `d` is pushed only if all of the following hold:
  - queue not full;
  - `d != ref`;
  - `d != ref ^ 2'b10`, i.e. not the opposite direction.
  - Otherwise the press is silently discarded.
- **Pop:** on `tick_i` with a non-empty queue, the head moves to `dir_o` and `turn_taken_o` pulses in the next cycle. `tick_i` with an empty queue leaves `dir_o` unchanged and gives no pulse.
- **Simultaneous push and pop (same cycle):**
  - The pop is evaluated first.
  - The push is checked against the post-pop reference: the remaining tail, or the popped direction if the queue empties.
  - Pushing into a full queue is allowed in that cycle.
- **Queue:** FIFO, depth 2, with 1-bit read/write pointers that wrap. Full = count 2, empty = count 0.

## Timing
- **Reset values:**
  - `dir_o` = 01 (right)
  - `turn_taken_o` = 0
  - `pending_o` = 0
  - queue empty, all stable levels 0, counters 0, synchronisers 0.
- **Press latency:** a clean press held high takes 2 (sync) + `DEBOUNCE_MAX` cycles to reach the stable level, plus 1 cycle for the edge to be pushed. `pending_o` updates registered.
- **Pop latency:** `dir_o` updates on the `clk` edge that samples `tick_i` high. `turn_taken_o` is high for exactly the following cycle.
- **Glitches:** a glitch shorter than `DEBOUNCE_MAX` cycles produces no event.
- **Release:** release is also debounced but generates no event.
- **Reset mid-operation:** asserting `rst` at any time immediately clears the queue and restores the reset values, with no `turn_taken_o` pulse.

## Configuration
- `SNAKE_TURN_QUEUE_EN` defined: queue depth 2, as described above.
- `SNAKE_TURN_QUEUE_EN` undefined:
  - depth 1 (single pending register);
  - `pending_o` is 0 or 1;
  - a second valid press before `tick_i` is dropped.
- Port list is identical in both builds.

## Structure
- **Package `snake_pkg`:**
  - `dir_t` (2-bit) with `DIR_UP`, `DIR_RIGHT`, `DIR_DOWN`, `DIR_LEFT`;
  - `DIR_RESET = DIR_RIGHT`;
  - function `dir_opposite(d) = d ^ 2'b10`.
  - The package is shared with the movement engine.
- **Sub-module `snake_debounce`:** one per button, instantiated 4×. Contains the synchroniser, the counter and the stable level, and outputs `level_o` and `rise_o`.

## Test plan
All scenarios use `DEBOUNCE_MAX`=4.
1. **Reset:** assert `rst` → `dir_o`=01, `pending_o`=0, `turn_taken_o`=0.
2. **Single turn:**
   - Hold up for 10 cycles → `pending_o`=1 at cycle 7 after the press.
   - Pulse `tick_i` → `dir_o`=00, `turn_taken_o` high for one cycle, `pending_o`=0.
3. **Illegal turns:** with `dir_o`=01, press left → discarded (`pending_o` stays 0); press right → discarded.
4. **Double tap:**
   - From right, press up then left with no tick in between → `pending_o`=2.
   - Two ticks → `dir_o` goes 00, then 11.
   - A third press while full is dropped.
5. **Glitch:** a 3-cycle pulse on down → no event. Simultaneous up+down presses → only up is queued.
6. **Corner cases:**
   - `tick_i` coinciding with the push-accept cycle of an opposite-of-head press → rejected against the popped direction.
   - `rst` asserted mid-queue → immediate clear.
   - Build without `SNAKE_TURN_QUEUE_EN` → `pending_o` never exceeds 1.
